switch_debounce: RTL and testbench
==================================

# switch_debounce

Board-input conditioning stage sitting directly upstream of the CPU top level: takes the raw, asynchronous 16 slide switches and produces the synchronized, debounced switch vector the CPU's memory-mapped switch register reads. Also emits single-cycle rise/fall pulses per bit for a future interrupt or event source. Replaces the direct pad-to-core connection of the switches.

## Interface
- WIDTH, 16, number of switch bits conditioned.
- DEBOUNCE_CYCLES, 500000, consecutive clk cycles a synchronized input must differ from the debounced value before it is accepted (5 ms at 100 MHz); legal range 2 .. 2^24.
- clk  input  1  system clock; the single clock for the block.
- rst_n  input  1  reset; synchronous, active-low.
- sw_raw  input  WIDTH  raw switch pads, asynchronous to clk.
- sw_debounced  output  WIDTH  debounced switch state; drives the core's boardSwitches.
- sw_rise  output  WIDTH  one-cycle pulse per bit when sw_debounced bit goes 0->1.
- sw_fall  output  WIDTH  one-cycle pulse per bit when sw_debounced bit goes 1->0.
- sw_changed  output  1  OR-reduction of sw_rise | sw_fall, registered with them.

## Operation
- Per bit, independently: 2-flop synchronizer (sync1, sync2), then a stability counter cnt of width $clog2(DEBOUNCE_CYCLES).
- Per-bit state machine, 2 states:
  - IDLE: sync2 == sw_debounced; cnt held at 0. sync2 != sw_debounced -> COUNT, cnt <= 1.
  - COUNT: if sync2 == sw_debounced (glitch ended) -> IDLE, cnt <= 0. Else if cnt == DEBOUNCE_CYCLES-1 -> sw_debounced <= sync2, edge pulse asserted, cnt <= 0, -> IDLE. Else cnt <= cnt + 1.
- A glitch shorter than DEBOUNCE_CYCLES mismatch cycles never changes the output; any return to the old value restarts counting from 0.
- Counter never wraps: terminal compare is ==, and cnt is cleared on acceptance.
- sw_rise[i] = 1 only in the cycle after sw_debounced[i] changes 0->1; sw_fall[i] symmetric; both deasserted all other cycles; never both set for the same bit.
- Bits are fully independent; simultaneous transitions on several bits produce simultaneous pulses.
- Reset (rst_n low at a clk edge): sync1, sync2, cnt, state, sw_debounced, sw_rise, sw_fall, sw_changed all <= 0. No pulse generated on reset release even if switches are high; a high switch is accepted through the normal counting path afterwards and then does produce sw_rise.
- Reset asserted mid-count abandons the count; no partial acceptance.

## Timing
- Raw change first sampled at edge k: sync2 valid after edge k+1; mismatch counted at edges k+2 .. k+1+DEBOUNCE_CYCLES; sw_debounced updates at edge k+1+DEBOUNCE_CYCLES, i.e. latency DEBOUNCE_CYCLES+2 edges from first sampling edge.
- sw_rise/sw_fall/sw_changed are registered and asserted for exactly the cycle following the edge that updates sw_debounced... specifically they are set at the same edge as sw_debounced and cleared at the next edge.
- All outputs are registered; no combinational path from sw_raw to any output.
- Reset values: every output 0.

## Structure
- Shared package board_io_pkg: SYNC_STAGES = 2, DEBOUNCE_CYCLES_DEFAULT = 500000, debounce_state_t enum {DB_IDLE, DB_COUNT}.
- One sub-module: bit_debouncer (single bit: synchronizer, counter, FSM, rise/fall), instantiated WIDTH times via generate; switch_debounce adds only the sw_changed reduction register.
- Elaboration-time assertion: DEBOUNCE_CYCLES >= 2.

## Test plan
(All with DEBOUNCE_CYCLES = 4, WIDTH = 16.)
- Reset: hold rst_n=0 3 cycles with sw_raw=16'hFFFF -> all outputs 0; after release sw_debounced=16'hFFFF exactly 6 edges after first sampling edge, with sw_rise=16'hFFFF and sw_changed=1 for one cycle.
- Clean step: sw_raw 16'h0000 -> 16'h0001 held -> sw_debounced=16'h0001 at edge k+5, sw_rise=16'h0001 for one cycle, sw_fall=0.
- Glitch rejection: bit 3 high for 3 cycles then low -> sw_debounced, sw_rise, sw_changed stay 0 throughout.
- Bounce then settle: bit 7 toggles 1,0,1,0,1 one cycle each then stays 1 -> exactly one sw_rise[7] pulse, 6 edges after the final rising sample.
- Simultaneous multi-bit: sw_raw 16'h00FF -> 16'hFF00 at once -> same edge: sw_debounced=16'hFF00, sw_rise=16'hFF00, sw_fall=16'h00FF, sw_changed=1.
- Reset mid-count: bit 0 high, assert rst_n=0 after 2 counted cycles, release -> no pulse before a fresh full 6-edge latency; sw_debounced[0] then 1.

Source files
------------

// File: rtl/board_io_pkg.sv
// Shared board-I/O definitions: synchronizer depth, default debounce window
// and the per-bit debounce state encoding.
package board_io_pkg;

    localparam int unsigned SYNC_STAGES             = 2;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;

    typedef enum logic {
        DB_IDLE  = 1'b0,
        DB_COUNT = 1'b1
    } debounce_state_t;

endpackage : board_io_pkg

// File: rtl/bit_debouncer.sv
// Single-bit switch conditioner: 2-flop synchronizer, stability counter,
// two-state accept FSM and registered rise/fall pulses.
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   raw        asynchronous switch pad
//   debounced  accepted (debounced) switch level
//   rise       one-cycle pulse on accepted 0->1
//   fall       one-cycle pulse on accepted 1->0
//   changed_c  combinational: a pulse will be registered at the next edge
module bit_debouncer
    import board_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic debounced,
    output logic rise,
    output logic fall,
    output logic changed_c
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   stable;
    debounce_state_t        state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic                   debounced_nxt;
    logic                   rise_nxt;
    logic                   fall_nxt;

    // Last synchronizer stage is the only copy of the input the FSM sees.
    assign stable = sync[SYNC_STAGES-1];

    // State, counter, synchronizer and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync      <= '0;
            state     <= DB_IDLE;
            cnt       <= '0;
            debounced <= 1'b0;
            rise      <= 1'b0;
            fall      <= 1'b0;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], raw};
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            debounced <= debounced_nxt;
            rise      <= rise_nxt;
            fall      <= fall_nxt;
        end
    end

    // Next-state logic: accept only after DEBOUNCE_CYCLES consecutive mismatches.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        debounced_nxt = debounced;
        rise_nxt      = 1'b0;
        fall_nxt      = 1'b0;
        case (state)
            DB_IDLE: begin
                cnt_nxt = '0;
                if (stable != debounced) begin
                    state_nxt = DB_COUNT;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            DB_COUNT: begin
                if (stable == debounced) begin
                    state_nxt = DB_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    // Terminal count: take the new level and clear so cnt never wraps.
                    debounced_nxt = stable;
                    rise_nxt      = stable;
                    fall_nxt      = ~stable;
                    cnt_nxt       = '0;
                    state_nxt     = DB_IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = DB_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign changed_c = rise_nxt | fall_nxt;

endmodule : bit_debouncer

// File: rtl/switch_debounce.sv
// Slide-switch conditioning stage: per-bit synchronize + debounce, with
// per-bit rise/fall pulses and a registered any-change flag.
// Ports:
//   clk           system clock
//   rst_n         synchronous active-low reset
//   sw_raw        raw switch pads (asynchronous)
//   sw_debounced  debounced switch vector
//   sw_rise       per-bit one-cycle 0->1 pulse
//   sw_fall       per-bit one-cycle 1->0 pulse
//   sw_changed    OR of sw_rise | sw_fall, same cycle as the pulses
module switch_debounce
    import board_io_pkg::*;
#(
    parameter int unsigned WIDTH           = 16,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_debounced,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed
);

    // Window of one cycle would make the counter zero bits wide.
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
        $error("switch_debounce: DEBOUNCE_CYCLES must be >= 2");
    end

    logic [WIDTH-1:0] bit_changed_c;

    // One independent conditioner per switch.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        bit_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk       (clk),
            .rst_n     (rst_n),
            .raw       (sw_raw[i]),
            .debounced (sw_debounced[i]),
            .rise      (sw_rise[i]),
            .fall      (sw_fall[i]),
            .changed_c (bit_changed_c[i])
        );
    end

    // Registered from the pulses' next values so it lines up with them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sw_changed <= 1'b0;
        end else begin
            sw_changed <= |bit_changed_c;
        end
    end

endmodule : switch_debounce

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce: directed test-plan scenarios plus random
// switch activity, scored against a behavioural model through a queue.
module tb_switch_debounce;

    localparam int unsigned W = 16;
    localparam int unsigned D = 4;

    typedef struct packed {
        logic [W-1:0] deb;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         chg;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_debounced;
    logic [W-1:0] sw_rise;
    logic [W-1:0] sw_fall;
    logic         sw_changed;

    int checks = 0;
    int errors = 0;
    bit done   = 1'b0;

    exp_t exp_q[$];

    switch_debounce #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw_raw       (sw_raw),
        .sw_debounced (sw_debounced),
        .sw_rise      (sw_rise),
        .sw_fall      (sw_fall),
        .sw_changed   (sw_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: raw is visible to the decision two edges after it is
    // sampled; a bit flips after D consecutive edges of disagreement.
    logic [W-1:0] m_pipe[$];
    logic [W-1:0] m_deb;
    int           m_run[W];

    initial begin
        m_deb = '0;
        for (int i = 0; i < int'(W); i++) m_run[i] = 0;
        forever begin
            exp_t e;
            logic [W-1:0] seen;
            @(posedge clk);
            e = '0;
            if (!rst_n) begin
                m_pipe = {};
                m_pipe.push_back('0);
                m_pipe.push_back('0);
                m_deb = '0;
                for (int i = 0; i < int'(W); i++) m_run[i] = 0;
            end else begin
                if (m_pipe.size() < 2) begin
                    m_pipe = {};
                    m_pipe.push_back('0);
                    m_pipe.push_back('0);
                end
                seen = m_pipe.pop_front();
                m_pipe.push_back(sw_raw);
                for (int i = 0; i < int'(W); i++) begin
                    if (seen[i] != m_deb[i]) begin
                        m_run[i]++;
                        if (m_run[i] == int'(D)) begin
                            m_run[i] = 0;
                            m_deb[i] = seen[i];
                            if (seen[i]) e.rise[i] = 1'b1;
                            else         e.fall[i] = 1'b1;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
            end
            e.deb = m_deb;
            e.chg = |(e.rise | e.fall);
            exp_q.push_back(e);
        end
    end

    // Monitor: one registered output set per cycle, compared mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (done) break;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_debounced", 32'(sw_debounced), 32'(e.deb));
                chk("sb_rise",      32'(sw_rise),      32'(e.rise));
                chk("sb_fall",      32'(sw_fall),      32'(e.fall));
                chk("sb_changed",   32'(sw_changed),   32'(e.chg));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n  = 1'b0;
        sw_raw = 16'hFFFF;

        // Reset with switches high: nothing leaks out.
        tick(3);
        chk("rst_deb",  32'(sw_debounced), 32'h0);
        chk("rst_rise", 32'(sw_rise),      32'h0);
        chk("rst_chg",  32'(sw_changed),   32'h0);
        rst_n = 1'b1;
        tick(5);
        chk("rel_deb_early", 32'(sw_debounced), 32'h0);
        tick(1);
        chk("rel_deb",  32'(sw_debounced), 32'hFFFF);
        chk("rel_rise", 32'(sw_rise),      32'hFFFF);
        chk("rel_chg",  32'(sw_changed),   32'h1);
        tick(1);
        chk("rel_rise_clr", 32'(sw_rise),    32'h0);
        chk("rel_chg_clr",  32'(sw_changed), 32'h0);

        sw_raw = 16'h0000;
        tick(8);
        chk("settle0", 32'(sw_debounced), 32'h0);

        // Clean step on bit 0.
        sw_raw = 16'h0001;
        tick(5);
        chk("step_deb_early", 32'(sw_debounced), 32'h0);
        tick(1);
        chk("step_deb",  32'(sw_debounced), 32'h0001);
        chk("step_rise", 32'(sw_rise),      32'h0001);
        chk("step_fall", 32'(sw_fall),      32'h0000);
        tick(1);
        chk("step_rise_clr", 32'(sw_rise), 32'h0);

        // Glitch on bit 3 shorter than the window.
        sw_raw = 16'h0009;
        tick(3);
        sw_raw = 16'h0001;
        tick(10);
        chk("glitch_deb", 32'(sw_debounced), 32'h0001);

        // Bounce on bit 7 then settle high.
        sw_raw = 16'h0081; tick(1);
        sw_raw = 16'h0001; tick(1);
        sw_raw = 16'h0081; tick(1);
        sw_raw = 16'h0001; tick(1);
        sw_raw = 16'h0081;
        tick(5);
        chk("bounce_deb_early", 32'(sw_debounced), 32'h0001);
        tick(1);
        chk("bounce_deb",  32'(sw_debounced), 32'h0081);
        chk("bounce_rise", 32'(sw_rise),      32'h0080);

        // Simultaneous multi-bit swap.
        sw_raw = 16'h00FF;
        tick(8);
        sw_raw = 16'hFF00;
        tick(6);
        chk("multi_deb",  32'(sw_debounced), 32'hFF00);
        chk("multi_rise", 32'(sw_rise),      32'hFF00);
        chk("multi_fall", 32'(sw_fall),      32'h00FF);
        chk("multi_chg",  32'(sw_changed),   32'h1);

        // Reset in the middle of a count.
        sw_raw = 16'h0000;
        tick(8);
        sw_raw = 16'h0001;
        tick(4);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(5);
        chk("midrst_deb_early",  32'(sw_debounced), 32'h0);
        chk("midrst_rise_early", 32'(sw_rise),      32'h0);
        tick(1);
        chk("midrst_deb",  32'(sw_debounced), 32'h0001);
        chk("midrst_rise", 32'(sw_rise),      32'h0001);

        // Random switch activity with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0)
                sw_raw = sw_raw ^ 16'($urandom & $urandom & $urandom);
            rst_n = ($urandom_range(0, 299) != 0);
            tick(1);
        end
        rst_n = 1'b1;
        tick(12);

        done = 1'b1;
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_switch_debounce
